// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the display counter blocks.
//   state_t        - sequencer FSM state encoding (IDLE/RUN/PAUSE, 2'b11 unused)
//   SEG_0..SEG_9   - active-low 7-segment patterns {g,f,e,d,c,b,a}
//   SEG_BLANK      - all segments off
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to active-low 7-segment decoder.
//   i_val [3:0] - value to show; 10..15 blank the digit
//   o_seg [6:0] - active-low segments {g,f,e,d,c,b,a}
module seg7_decode
  import counter_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_val)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: run/pause/step sequencer for a single-digit counter.
//   CLK, rst                - clock, async active-high reset
//   start/stop/step/clear   - level inputs, acted on at their rising edge
//   dir                     - 1 = count up, 0 = count down
//   oQ [3:0]                - current count
//   oDisplay [6:0]          - active-low segments for oQ
//   oState [1:0]            - FSM state
//   oTick / oWrap           - pulse in the cycle oQ takes an advanced / wrapped value
module counter_seq_ctrl
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int MODULUS  = 8
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       clear,
  input  logic       dir,
  output logic [3:0] oQ,
  output logic [6:0] oDisplay,
  output logic [1:0] oState,
  output logic       oTick,
  output logic       oWrap
);

  localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [3:0]      Q_MAX   = 4'(MODULUS - 1);

  state_t        r_state;
  logic [PW-1:0] r_pre;
  logic [3:0]    r_q;
  logic          r_tick, r_wrap;
  logic          r_start_q, r_stop_q, r_step_q, r_clear_q;

  logic w_start, w_stop, w_step, w_clear;
  logic w_stop_cmd, w_start_cmd, w_step_cmd;
  logic [3:0] w_nxt;
  logic       w_wrp;

  assign w_start = start & ~r_start_q;
  assign w_stop  = stop  & ~r_stop_q;
  assign w_step  = step  & ~r_step_q;
  assign w_clear = clear & ~r_clear_q;

  // Strict priority: only the highest asserted command is acted on,
  // even when that command has no effect in the current state.
  assign w_stop_cmd  = w_stop  & ~w_clear;
  assign w_start_cmd = w_start & ~w_stop & ~w_clear;
  assign w_step_cmd  = w_step  & ~w_start & ~w_stop & ~w_clear;

  // Next count for one advance in the sampled direction
  always_comb begin
    w_nxt = '0;
    w_wrp = 1'b0;
    if (dir) begin
      if (r_q == Q_MAX) w_wrp = 1'b1;
      else              w_nxt = r_q + 4'd1;
    end else begin
      if (r_q == 4'd0) begin
        w_nxt = Q_MAX;
        w_wrp = 1'b1;
      end else begin
        w_nxt = r_q - 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pre     <= '0;
      r_q       <= '0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
      r_start_q <= 1'b0;
      r_stop_q  <= 1'b0;
      r_step_q  <= 1'b0;
      r_clear_q <= 1'b0;
    end else begin
      r_start_q <= start;
      r_stop_q  <= stop;
      r_step_q  <= step;
      r_clear_q <= clear;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
      if (w_clear) begin
        r_state <= ST_IDLE;
        r_q     <= '0;
        r_pre   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_q   <= '0;
            r_pre <= '0;
            if (w_start_cmd) r_state <= ST_RUN;
          end
          ST_RUN: begin
            // stop on a rollover edge wins: prescaler parks at PRE_MAX
            if (w_stop_cmd) begin
              r_state <= ST_PAUSE;
            end else if (r_pre == PRE_MAX) begin
              r_pre  <= '0;
              r_q    <= w_nxt;
              r_tick <= 1'b1;
              r_wrap <= w_wrp;
            end else begin
              r_pre <= r_pre + PW'(1);
            end
          end
          ST_PAUSE: begin
            if (w_start_cmd) begin
              r_state <= ST_RUN;
              r_pre   <= '0;
            end else if (w_step_cmd) begin
              r_q    <= w_nxt;
              r_tick <= 1'b1;
              r_wrap <= w_wrp;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_pre   <= '0;
          end
        endcase
      end
    end
  end

  assign oQ     = r_q;
  assign oState = r_state;
  assign oTick  = r_tick;
  assign oWrap  = r_wrap;

  seg7_decode u_seg (
    .i_val (r_q),
    .o_seg (oDisplay)
  );

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: two instances (PRESCALE=4/MODULUS=8 and
// PRESCALE=1/MODULUS=10) share the inputs and are each tracked by a
// behavioural model; directed tables and sequences cover the corner cases.
module tb_counter_seq_ctrl;

  logic CLK = 1'b0, rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, step = 1'b0, clear = 1'b0, dir = 1'b1;
  logic [3:0] qa, qb;
  logic [6:0] da, db;
  logic [1:0] sa, sb;
  logic ta, tb, wa, wb;

  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  counter_seq_ctrl #(.PRESCALE(4), .MODULUS(8)) u_a (
    .CLK(CLK), .rst(rst), .start(start), .stop(stop), .step(step),
    .clear(clear), .dir(dir), .oQ(qa), .oDisplay(da), .oState(sa),
    .oTick(ta), .oWrap(wa));

  counter_seq_ctrl #(.PRESCALE(1), .MODULUS(10)) u_b (
    .CLK(CLK), .rst(rst), .start(start), .stop(stop), .step(step),
    .clear(clear), .dir(dir), .oQ(qb), .oDisplay(db), .oState(sb),
    .oTick(tb), .oWrap(wb));

  // mode: 0 idle, 1 run, 2 pause; ph = cycles spent in RUN since last advance
  typedef struct {
    int mode; int q; int ph; bit tk; bit wr;
    bit p_st; bit p_sp; bit p_sx; bit p_cl;
  } mdl_t;

  typedef struct {
    bit st; bit sp; bit sx; bit cl; bit dr;
    int q; int s; bit tk; bit wr;
  } vec_t;

  mdl_t ma, mb;
  vec_t tv[$];

  function automatic mdl_t mzero();
    mdl_t m;
    m = '{default: 0};
    return m;
  endfunction

  function automatic logic [6:0] seg(int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit st, bit sp, bit sx, bit cl, bit dr,
                                 int P, int M);
    int cmd;
    bit adv;
    adv = 1'b0;
    // 1 clear, 2 stop, 3 start, 4 step, 0 none
    if (cl && !m.p_cl)      cmd = 1;
    else if (sp && !m.p_sp) cmd = 2;
    else if (st && !m.p_st) cmd = 3;
    else if (sx && !m.p_sx) cmd = 4;
    else                    cmd = 0;
    m.p_st = st; m.p_sp = sp; m.p_sx = sx; m.p_cl = cl;
    m.tk = 1'b0; m.wr = 1'b0;
    if (cmd == 1) begin
      m.mode = 0; m.q = 0; m.ph = 0;
    end else if (m.mode == 0) begin
      if (cmd == 3) m.mode = 1;
    end else if (m.mode == 1) begin
      if (cmd == 2) m.mode = 2;
      else begin
        m.ph++;
        if (m.ph == P) begin m.ph = 0; adv = 1'b1; end
      end
    end else begin
      if (cmd == 3) begin m.mode = 1; m.ph = 0; end
      else if (cmd == 4) adv = 1'b1;
    end
    if (adv) begin
      m.tk = 1'b1;
      if (dr) begin m.wr = (m.q == M - 1); m.q = (m.q + 1) % M; end
      else    begin m.wr = (m.q == 0);     m.q = (m.q + M - 1) % M; end
    end
    return m;
  endfunction

  function automatic vec_t V(bit st, bit sp, bit sx, bit cl, bit dr,
                             int q, int s, bit tk, bit wr);
    vec_t v;
    v.st = st; v.sp = sp; v.sx = sx; v.cl = cl; v.dr = dr;
    v.q = q; v.s = s; v.tk = tk; v.wr = wr;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(string tag, logic [3:0] q, logic [6:0] d, logic [1:0] s,
                         logic tk, logic wr, mdl_t m);
    chk({tag, ".q"},     int'(q),  m.q);
    chk({tag, ".disp"},  int'(d),  int'(seg(m.q)));
    chk({tag, ".state"}, int'(s),  m.mode);
    chk({tag, ".tick"},  int'(tk), int'(m.tk));
    chk({tag, ".wrap"},  int'(wr), int'(m.wr));
  endtask

  task automatic cyc();
    ma = mstep(ma, start, stop, step, clear, dir, 4, 8);
    mb = mstep(mb, start, stop, step, clear, dir, 1, 10);
    @(posedge CLK);
    #1;
    cmp_dut("modelA", qa, da, sa, ta, wa, ma);
    cmp_dut("modelB", qb, db, sb, tb, wb, mb);
  endtask

  initial begin
    ma = mzero();
    mb = mzero();

    // Reset state
    #12;
    chk("rst.q", int'(qa), 0);
    chk("rst.disp", int'(da), int'(7'b1000000));
    chk("rst.state", int'(sa), 0);
    chk("rst.tick", int'(ta), 0);
    chk("rst.wrap", int'(wa), 0);
    chk("rstB.q", int'(qb), 0);
    #5 rst = 1'b0;

    // Run up 0..7,0..3 at 4-cycle spacing
    start = 1'b1; dir = 1'b1;
    cyc();
    chk("run.enter", int'(sa), 1);
    chk("run.q0", int'(qa), 0);
    start = 1'b0;
    for (int j = 1; j <= 44; j++) begin
      cyc();
      chk("run.q", int'(qa), (j / 4) % 8);
      chk("run.disp", int'(da), int'(seg((j / 4) % 8)));
      chk("run.tick", int'(ta), int'(j % 4 == 0));
      chk("run.wrap", int'(wa), int'(j == 32));
    end

    // Pause/step/wrap/priority table (one row per edge), DUT A expectations
    //           st sp sx cl dr  q  s tk wr
    tv.push_back(V(0, 1, 0, 0, 1, 3, 2, 0, 0));
    tv.push_back(V(0, 0, 0, 0, 0, 3, 2, 0, 0));
    tv.push_back(V(0, 0, 1, 0, 0, 2, 2, 1, 0));
    tv.push_back(V(0, 0, 0, 0, 0, 2, 2, 0, 0));
    tv.push_back(V(0, 0, 1, 0, 0, 1, 2, 1, 0));
    tv.push_back(V(0, 0, 0, 0, 0, 1, 2, 0, 0));
    tv.push_back(V(0, 0, 1, 0, 0, 0, 2, 1, 0));
    tv.push_back(V(0, 0, 0, 0, 0, 0, 2, 0, 0));
    tv.push_back(V(0, 0, 1, 0, 0, 7, 2, 1, 1));
    tv.push_back(V(0, 0, 0, 0, 0, 7, 2, 0, 0));
    tv.push_back(V(0, 0, 1, 0, 1, 0, 2, 1, 1));
    tv.push_back(V(0, 0, 0, 0, 1, 0, 2, 0, 0));
    tv.push_back(V(0, 1, 1, 0, 1, 0, 2, 0, 0));
    tv.push_back(V(0, 0, 0, 0, 1, 0, 2, 0, 0));
    tv.push_back(V(0, 0, 1, 0, 1, 1, 2, 1, 0));
    tv.push_back(V(0, 0, 0, 0, 1, 1, 2, 0, 0));
    tv.push_back(V(1, 0, 0, 1, 1, 0, 0, 0, 0));
    tv.push_back(V(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(V(0, 1, 1, 0, 1, 0, 0, 0, 0));
    tv.push_back(V(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(V(1, 0, 0, 0, 1, 0, 1, 0, 0));
    tv.push_back(V(0, 0, 0, 0, 1, 0, 1, 0, 0));
    tv.push_back(V(0, 0, 0, 0, 1, 0, 1, 0, 0));
    tv.push_back(V(0, 0, 0, 0, 1, 0, 1, 0, 0));
    tv.push_back(V(0, 1, 0, 0, 1, 0, 2, 0, 0));
    tv.push_back(V(0, 0, 0, 0, 1, 0, 2, 0, 0));
    tv.push_back(V(1, 0, 0, 0, 1, 0, 1, 0, 0));
    tv.push_back(V(0, 0, 0, 0, 1, 0, 1, 0, 0));
    tv.push_back(V(0, 0, 1, 0, 1, 0, 1, 0, 0));
    tv.push_back(V(0, 0, 0, 0, 1, 0, 1, 0, 0));
    tv.push_back(V(0, 0, 0, 0, 1, 1, 1, 1, 0));
    tv.push_back(V(0, 0, 0, 1, 1, 0, 0, 0, 0));
    foreach (tv[i]) begin
      start = tv[i].st; stop = tv[i].sp; step = tv[i].sx;
      clear = tv[i].cl; dir = tv[i].dr;
      cyc();
      chk($sformatf("tv%0d.q", i),     int'(qa), tv[i].q);
      chk($sformatf("tv%0d.state", i), int'(sa), tv[i].s);
      chk($sformatf("tv%0d.tick", i),  int'(ta), int'(tv[i].tk));
      chk($sformatf("tv%0d.wrap", i),  int'(wa), int'(tv[i].wr));
      chk($sformatf("tv%0d.disp", i),  int'(da), int'(seg(tv[i].q)));
    end

    // MODULUS=10, PRESCALE=1 run
    start = 1'b0; stop = 1'b0; step = 1'b0; clear = 1'b0; dir = 1'b1;
    cyc();
    clear = 1'b1; cyc();
    clear = 1'b0; start = 1'b1; cyc();
    chk("m10.enter", int'(sb), 1);
    start = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      cyc();
      chk("m10.q", int'(qb), j % 10);
      chk("m10.tick", int'(tb), 1);
      chk("m10.wrap", int'(wb), int'(j == 10));
      if (j == 9) chk("m10.disp9", int'(db), int'(7'b0010000));
    end

    // Async reset between edges, start held through release
    #3 rst = 1'b1; start = 1'b1;
    ma = mzero(); mb = mzero();
    #1;
    chk("arst.q", int'(qa), 0);
    chk("arst.disp", int'(da), int'(7'b1000000));
    chk("arst.state", int'(sa), 0);
    chk("arst.tick", int'(ta), 0);
    chk("arstB.q", int'(qb), 0);
    chk("arstB.state", int'(sb), 0);
    #2 rst = 1'b0;
    cyc();
    chk("arst.run", int'(sa), 1);
    chk("arstB.run", int'(sb), 1);
    start = 1'b0;

    // Random stimulus against the models
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom % 8 == 0);
      stop  = ($urandom % 10 == 0);
      step  = ($urandom % 4 == 0);
      clear = ($urandom % 40 == 0);
      if ($urandom % 16 == 0) dir = ~dir;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
